// File: rtl/gumnut_pkg.sv
// Shared Gumnut definitions: interrupt FSM state type, default PC width
// and interrupt vector address.
package gumnut_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    ISR,
    RESTORE
  } int_state_t;

  localparam int unsigned INT_PC_W = 12;
  localparam logic [INT_PC_W-1:0] INT_VEC_ADDR = 12'h001;

endpackage

// File: rtl/int_shadow.sv
// Return-PC and C/Z capture registers for the interrupt controller.
// Flag shadows exist only when INT_FLAG_SAVE_EN is defined.
module int_shadow
  import gumnut_pkg::*;
#(
  parameter int unsigned PC_W = INT_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            load,
  input  logic [PC_W-1:0] pc_i,
  input  logic            c_i,
  input  logic            z_i,
  output logic [PC_W-1:0] pc_o,
  output logic            c_o,
  output logic            z_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o <= '0;
    end else if (cen && load) begin
      pc_o <= pc_i;
    end
  end

`ifdef INT_FLAG_SAVE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      c_o <= 1'b0;
      z_o <= 1'b0;
    end else if (cen && load) begin
      c_o <= c_i;
      z_o <= z_i;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = c_i ^ z_i;
  assign c_o = 1'b0;
  assign z_o = 1'b0;
`endif

endmodule

// File: rtl/int_ctrl.sv
// Gumnut interrupt controller: takes one request per instruction boundary,
// redirects fetch to the vector and restores flags on reti (INT_FLAG_SAVE_EN).
module int_ctrl
  import gumnut_pkg::*;
#(
  parameter int unsigned          PC_W     = INT_PC_W,
  parameter logic [PC_W-1:0]      VEC_ADDR = INT_VEC_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            int_req,
  input  logic            inst_done,
  input  logic            reti,
  input  logic            enai,
  input  logic            disi,
  input  logic [PC_W-1:0] pc_i,
  input  logic            c_i,
  input  logic            z_i,
  output logic            int_take,
  output logic [PC_W-1:0] vec_o,
  output logic [PC_W-1:0] pc_save_o,
  output logic            int_ack,
  output logic            iwe_o,
  output logic            intc_o,
  output logic            intz_o,
  output logic            int_en_o,
  output logic            in_isr_o
);

`ifdef INT_FLAG_SAVE_EN
  localparam bit FLAG_SAVE = 1'b1;
`else
  localparam bit FLAG_SAVE = 1'b0;
`endif

  int_state_t state, state_next;
  logic       int_en;
  logic       sc, sz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (cen) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (inst_done && int_req && int_en) state_next = TAKE;
      TAKE:    state_next = ISR;
      ISR:     if (reti) state_next = RESTORE;
      RESTORE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // disi wins over enai; TAKE/RESTORE override both unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_en <= 1'b0;
    end else if (cen) begin
      unique case (state)
        TAKE:    int_en <= 1'b0;
        RESTORE: int_en <= 1'b1;
        default: begin
          if (disi)      int_en <= 1'b0;
          else if (enai) int_en <= 1'b1;
        end
      endcase
    end
  end

  int_shadow #(
    .PC_W (PC_W)
  ) u_shadow (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .load (state == TAKE),
    .pc_i (pc_i),
    .c_i  (c_i),
    .z_i  (z_i),
    .pc_o (pc_save_o),
    .c_o  (sc),
    .z_o  (sz)
  );

  always_comb begin
    int_take = 1'b0;
    int_ack  = 1'b0;
    in_isr_o = 1'b0;
    iwe_o    = 1'b0;
    intc_o   = 1'b0;
    intz_o   = 1'b0;
    unique case (state)
      TAKE: begin
        int_take = 1'b1;
        int_ack  = 1'b1;
      end
      ISR:     in_isr_o = 1'b1;
      RESTORE: begin
        iwe_o  = FLAG_SAVE;
        intc_o = FLAG_SAVE & sc;
        intz_o = FLAG_SAVE & sz;
      end
      default: ;
    endcase
  end

  assign int_en_o = int_en;
  assign vec_o    = VEC_ADDR;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed steps followed by random traffic,
// compared cycle by cycle against an event-level model of the controller.
module tb_int_ctrl;

  localparam int PW = 12;
  localparam logic [PW-1:0] VEC = 12'h001;
`ifdef INT_FLAG_SAVE_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, cen = 1'b1, int_req = 1'b0, inst_done = 1'b0;
  logic          reti = 1'b0, enai = 1'b0, disi = 1'b0, c_i = 1'b0, z_i = 1'b0;
  logic [PW-1:0] pc_i = '0;
  logic          int_take, int_ack, iwe_o, intc_o, intz_o, int_en_o, in_isr_o;
  logic [PW-1:0] vec_o, pc_save_o;

  int checks = 0;
  int failures = 0;

  // Model: enable flag, "handler running", one-cycle take/restore pulses pending
  bit            m_en, m_handler, m_take, m_restore, m_c, m_z;
  logic [PW-1:0] m_pc;

  int_ctrl #(
    .PC_W     (PW),
    .VEC_ADDR (VEC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .int_req   (int_req),
    .inst_done (inst_done),
    .reti      (reti),
    .enai      (enai),
    .disi      (disi),
    .pc_i      (pc_i),
    .c_i       (c_i),
    .z_i       (z_i),
    .int_take  (int_take),
    .vec_o     (vec_o),
    .pc_save_o (pc_save_o),
    .int_ack   (int_ack),
    .iwe_o     (iwe_o),
    .intc_o    (intc_o),
    .intz_o    (intz_o),
    .int_en_o  (int_en_o),
    .in_isr_o  (in_isr_o)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit qualify;
    if (rst) begin
      m_en = 0; m_handler = 0; m_take = 0; m_restore = 0;
      m_pc = '0; m_c = 0; m_z = 0;
    end else if (cen) begin
      if (m_take) begin
        m_pc = pc_i; m_c = FS & c_i; m_z = FS & z_i;
        m_en = 0; m_take = 0; m_handler = 1;
      end else if (m_restore) begin
        m_en = 1; m_restore = 0;
      end else begin
        qualify = !m_handler && inst_done && int_req && m_en;
        if (m_handler && reti) begin
          m_handler = 0; m_restore = 1;
        end
        if (qualify) m_take = 1;
        if (disi)      m_en = 0;
        else if (enai) m_en = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("int_take",  PW'(int_take),  PW'(m_take));
    chk("int_ack",   PW'(int_ack),   PW'(m_take));
    chk("in_isr",    PW'(in_isr_o),  PW'(m_handler));
    chk("iwe",       PW'(iwe_o),     PW'(FS & m_restore));
    chk("intc",      PW'(intc_o),    PW'(FS & m_restore & m_c));
    chk("intz",      PW'(intz_o),    PW'(FS & m_restore & m_z));
    chk("int_en",    PW'(int_en_o),  PW'(m_en));
    chk("pc_save",   pc_save_o,      m_pc);
    chk("vec",       vec_o,          12'h001);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    int_req = 0; inst_done = 0; reti = 0; enai = 0; disi = 0; cen = 1; rst = 0;
  endtask

  initial begin
    // Reset state
    rst = 1; step(); step();
    idle_inputs();
    step();

    // 1: enable, then take with pc 040, C=1, Z=0
    enai = 1; step(); enai = 0;
    int_req = 1; inst_done = 1; pc_i = 12'h040; c_i = 1; z_i = 0; step();
    chk("take_latency", PW'(int_take), PW'(1));
    inst_done = 0; int_req = 0; step();
    chk("saved_pc", pc_save_o, 12'h040);
    pc_i = 12'h123; c_i = 0; z_i = 1;
    for (int i = 0; i < 3; i++) begin int_req = 1; inst_done = (i == 1); step(); end
    int_req = 0; inst_done = 0;

    // 2: reti -> restore pulse, then idle with interrupts enabled
    reti = 1; inst_done = 1; step(); reti = 0; inst_done = 0;
    chk("restore_iwe", PW'(iwe_o), PW'(FS));
    step();
    chk("reenabled", PW'(int_en_o), PW'(1));

    // 3: request while disabled, then enabled but without inst_done
    disi = 1; step(); disi = 0;
    int_req = 1; inst_done = 1;
    for (int i = 0; i < 20; i++) step();
    enai = 1; inst_done = 0; step(); enai = 0;
    for (int i = 0; i < 20; i++) step();

    // 5: take, stretched by cen=0, request dropped mid-TAKE
    inst_done = 1; disi = 1; pc_i = 12'h7fe; c_i = 1; z_i = 1; step();
    inst_done = 0; disi = 0; int_req = 0;
    cen = 0; for (int i = 0; i < 3; i++) step();
    cen = 1; step();
    cen = 0; step(); step();
    cen = 1; step();
    reti = 1; inst_done = 1; step(); reti = 0; inst_done = 0;
    cen = 0; for (int i = 0; i < 3; i++) step();
    cen = 1; step(); step();

    // 4: enai+disi together, reti in idle
    enai = 1; disi = 1; step(); enai = 0; disi = 0;
    reti = 1; inst_done = 1; step(); reti = 0; inst_done = 0;
    step();

    // 6: reset while in ISR
    enai = 1; step(); enai = 0;
    int_req = 1; inst_done = 1; pc_i = 12'habc; step();
    int_req = 0; inst_done = 0; step(); step();
    rst = 1; cen = 0; step();
    chk("rst_in_isr_pc", pc_save_o, 12'h000);
    rst = 0; cen = 1; step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cen       = ($urandom_range(3) != 0);
      rst       = ($urandom_range(80) == 0);
      inst_done = ($urandom_range(2) == 0);
      reti      = inst_done && ($urandom_range(3) == 0);
      int_req   = ($urandom_range(1) == 0);
      enai      = ($urandom_range(4) == 0);
      disi      = ($urandom_range(7) == 0);
      pc_i      = PW'($urandom);
      c_i       = $urandom_range(1) == 1;
      z_i       = $urandom_range(1) == 1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
